// File: rtl/aes_chip_pkg.sv
// aes_chip_pkg: shared widths and drain-engine state encoding for the AES chip datapath.
package aes_chip_pkg;
    localparam int AES_BLK_W = 128;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;
endpackage

// File: rtl/fifo128_unpack_rd.sv
// fifo128_unpack_rd: pops 128-bit FIFO words and streams them MSB-first as OUT_W-bit beats.
module fifo128_unpack_rd
    import aes_chip_pkg::*;
#(
    parameter int DATA_W = AES_BLK_W,
    parameter int OUT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_data,
    output logic              o_fifo_rd_en,
    output logic [OUT_W-1:0]  o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_last,
    output logic              o_busy
);
    localparam int BEATS = DATA_W / OUT_W;
    localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_buf;
    logic              w_send, w_last, w_hs, w_pop;

    assign w_send = r_state == ST_SEND;
    assign w_last = r_cnt == LAST_CNT;
    assign w_hs   = w_send && i_out_ready && !i_clr;
    // Refill on the last-beat handshake so back-to-back words cost only the LOAD bubble.
    assign w_pop  = i_rst_n && !i_clr && !i_fifo_empty && (r_state == ST_IDLE || (w_hs && w_last));

    always_comb begin
        w_next = r_state;
        if (i_clr)
            w_next = ST_IDLE;
        else
            case (r_state)
                ST_IDLE: w_next = w_pop ? ST_LOAD : ST_IDLE;
                ST_LOAD: w_next = ST_SEND;
                ST_SEND: w_next = (w_hs && w_last) ? (w_pop ? ST_LOAD : ST_IDLE) : ST_SEND;
                default: w_next = ST_IDLE;
            endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
        end else if (i_clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_LOAD) begin
                r_buf <= i_fifo_data;
                r_cnt <= '0;
            end else if (w_hs) begin
                r_buf <= r_buf << OUT_W;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign o_fifo_rd_en = w_pop;
    assign o_out_data   = r_buf[DATA_W-1 -: OUT_W];
    assign o_out_valid  = w_send;
    assign o_out_last   = w_send && w_last;
    assign o_busy       = r_state != ST_IDLE;
endmodule
